// File: rtl/rv32i_bus_pkg.sv
// rv32i_bus_pkg: address map, IO offsets, status bits and UART states for the rv32i memory bus
package rv32i_bus_pkg;
  localparam logic [31:0] DEF_RAM_BASE = 32'hf0000000;
  localparam logic [31:0] DEF_IO_BASE = 32'h80000000;
  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CYCLE = 4'h8;
  localparam int ST_BUSY = 0;
  localparam int ST_OVF = 1;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
endpackage

// File: rtl/rv32i_mem_bus_uart_tx.sv
// uart_tx: 8N1 serial transmitter, one state per bit period, done pulses in the last STOP cycle
module uart_tx import rv32i_bus_pkg::*; #(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(BAUD_DIV);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_i;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    state_n = load ? U_START : !last ? state :
              state == U_START ? U_DATA :
              state == U_DATA ? (bit_i == 3'd7 ? U_STOP : U_DATA) :
              state == U_STOP ? U_IDLE : state;
    tx = state == U_START ? 1'b0 : state == U_DATA ? sh[0] : 1'b1;
    busy = state != U_IDLE;
    done = state == U_STOP && last;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= U_IDLE;
      cnt <= '0;
      bit_i <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (load || last || state == U_IDLE) ? '0 : cnt + 1'b1;
      if (load) begin
        sh <= data;
        bit_i <= '0;
      end else if (state == U_DATA && last) begin
        sh <= sh >> 1;
        bit_i <= bit_i + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rv32i_mem_bus.sv
// rv32i_mem_bus: RAM/UART/cycle-counter slave for the rv32i core with registered 1-cycle reads
module rv32i_mem_bus import rv32i_bus_pkg::*; #(
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter int          BAUD_DIV  = 217,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_out,
  input  logic [3:0]  mem_wr_mask,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] mem_data_in,
  output logic        hold,
  output logic        uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycle, status, rdata;
  logic [29:0] word, ram_ofs;
  logic [AW-1:0] idx;
  logic [3:0] ofs;
  logic [7:0] pend_byte;
  logic ram_hit, io_hit, tx_wr, st_clr, load, pending, overflow, busy, done;
  always_comb begin
    word = mem_addr[31:2];
    ram_ofs = word - RAM_BASE[31:2];
    ram_hit = word >= RAM_BASE[31:2] && ram_ofs < 30'(RAM_WORDS);
    idx = mem_addr[AW+1:2];
    io_hit = mem_addr[31:4] == IO_BASE[31:4];
    ofs = {mem_addr[3:2], 2'b00};
    tx_wr = mem_wr && io_hit && ofs == OFS_TXDATA && mem_wr_mask[0];
    st_clr = mem_wr && io_hit && ofs == OFS_STATUS && mem_data_out[ST_OVF];
    load = pending ? done : tx_wr && (!busy || done);
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_OVF] = overflow;
    rdata = ram_hit ? ram[idx] : !io_hit ? 32'h0 :
            ofs == OFS_STATUS ? status : ofs == OFS_CYCLE ? cycle : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (mem_wr && ram_hit)
      for (int i = 0; i < 4; i++)
        if (mem_wr_mask[i]) ram[idx][8*i +: 8] <= mem_data_out[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_data_in <= '0;
      cycle <= '0;
      pending <= 1'b0;
      pend_byte <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (mem_rd) mem_data_in <= rdata;
      pending <= pending ? !done : tx_wr && busy && !done;
      if (tx_wr && busy && !done && !pending) pend_byte <= mem_data_out[7:0];
      overflow <= (overflow && !st_clr) || (tx_wr && pending);
    end
  end
  assign hold = pending;
  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .data(pending ? pend_byte : mem_data_out[7:0]),
    .tx(uart_tx),
    .busy(busy),
    .done(done)
  );
endmodule

// File: tb/tb_rv32i_mem_bus.sv
// tb_rv32i_mem_bus: directed and randomized checks of RAM, decode, cycle counter and UART framing
module tb_rv32i_mem_bus;
  localparam int RW = 256;
  localparam int BD = 4;
  localparam logic [31:0] RB = 32'hf0000000;
  localparam logic [31:0] IOB = 32'h80000000;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] mem_addr = '0, mem_data_out = '0;
  logic [3:0] mem_wr_mask = '0;
  logic mem_wr = 1'b0, mem_rd = 1'b0;
  logic [31:0] mem_data_in;
  logic hold, uart_tx;
  int n_cmp = 0, n_bad = 0;
  int unsigned cyc_ref = 0;
  logic [31:0] mref [RW];
  logic [31:0] exp_c;
  logic [7:0] rb;

  rv32i_mem_bus #(.RAM_WORDS(RW), .RAM_BASE(RB), .IO_BASE(IOB), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_wr_mask(mem_wr_mask), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data_in(mem_data_in), .hold(hold), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ref <= reset_n ? cyc_ref + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_rd = rd; mem_wr = wr; mem_addr = a; mem_data_out = d; mem_wr_mask = m;
    tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // RAM access through the model: reads see the word before this cycle's write
  task automatic ram_op(input logic rd, input logic wr, input int i, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] e;
    e = mref[i];
    bus(rd, wr, RB + 32'(4 * i) + 32'($urandom_range(0, 3)), d, m);
    if (rd) chk("ram_rd", mem_data_in, e);
    if (wr) for (int l = 0; l < 4; l++) if (m[l]) mref[i][8*l +: 8] = d[8*l +: 8];
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int n;
    n = k / BD;
    return n == 0 ? 1'b0 : n <= 8 ? b[n-1] : 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b);
    bus(1'b0, 1'b1, IOB, {$urandom_range(0, 255), 16'h0, b}, 4'b0001);
    for (int k = 1; k <= 41; k++) begin
      bus(1'b1, 1'b0, IOB + 32'h4, '0, '0);
      chk("frame_tx", uart_tx, frame_bit(b, k));
      chk("frame_busy", mem_data_in[0], k <= 40);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_hold", hold, 1'b0);
    chk("rst_rdata", mem_data_in, 32'h0);
    reset_n = 1'b1;
    tick();
    exp_c = cyc_ref;
    bus(1'b1, 1'b0, IOB + 32'h8, '0, '0);
    chk("cycle_first", mem_data_in, exp_c);
    chk("cycle_first_abs", mem_data_in, 32'd1);
    for (int i = 0; i < RW; i++) ram_op(1'b0, 1'b1, i, $urandom, 4'hf);
    ram_op(1'b0, 1'b1, 4, 32'hAABBCCDD, 4'b1111);
    ram_op(1'b0, 1'b1, 4, 32'h11111111, 4'b0010);
    bus(1'b1, 1'b0, 32'hf0000010, '0, '0);
    chk("byte_mask", mem_data_in, 32'hAABB11DD);
    bus(1'b1, 1'b1, 32'hf0000010, 32'h0, 4'hf);
    mref[4] = 32'h0;
    chk("rd_before_wr", mem_data_in, 32'hAABB11DD);
    ram_op(1'b1, 1'b0, 4, '0, '0);
    mref[5] = 32'h5a5a_0001;
    ram_op(1'b0, 1'b1, 5, 32'h5a5a_0001, 4'hf);
    ram_op(1'b1, 1'b0, 5, '0, '0);
    bus(1'b1, 1'b0, RB + 32'(4 * RW), '0, '0);
    chk("ram_past_end", mem_data_in, 32'h0);
    bus(1'b0, 1'b1, 32'h0, 32'hdeadbeef, 4'hf);
    bus(1'b0, 1'b1, RB + 32'(4 * RW), 32'hcafef00d, 4'hf);
    bus(1'b0, 1'b1, RB - 32'h4, 32'h12345678, 4'hf);
    ram_op(1'b1, 1'b0, 0, '0, '0);
    ram_op(1'b1, 1'b0, RW - 1, '0, '0);
    ram_op(1'b1, 1'b0, 5, '0, '0);
    bus(1'b1, 1'b0, IOB + 32'hC, '0, '0);
    chk("io_reserved", mem_data_in, 32'h0);
    ram_op(1'b1, 1'b0, 5, '0, '0);
    bus(1'b1, 1'b0, IOB, '0, '0);
    chk("io_txdata_rd", mem_data_in, 32'h0);
    ram_op(1'b1, 1'b0, 5, '0, '0);
    bus(1'b1, 1'b0, 32'h40000000, '0, '0);
    chk("unmapped_rd", mem_data_in, 32'h0);
    repeat (300) ram_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, RW - 1)), $urandom, 4'($urandom_range(0, 15)));
    send_frame(8'h55);
    bus(1'b0, 1'b1, IOB, 32'h30, 4'b0001);
    repeat (5) tick();
    bus(1'b0, 1'b1, IOB, 32'h41, 4'b0001);
    chk("hold_set", hold, 1'b1);
    tick();
    bus(1'b0, 1'b1, IOB, 32'h7e, 4'b0001);
    bus(1'b1, 1'b0, IOB + 32'h4, '0, '0);
    chk("status_ovf", mem_data_in, 32'h3);
    chk("hold_pend", hold, 1'b1);
    repeat (30) tick();
    chk("hold_stop", hold, 1'b1);
    chk("tx_stop", uart_tx, 1'b1);
    tick();
    chk("hold_drop", hold, 1'b0);
    chk("tx_back2back", uart_tx, 1'b0);
    for (int t = 41; t <= 59; t++) begin
      tick();
      chk("frame2_tx", uart_tx, frame_bit(8'h41, t - 40));
    end
    bus(1'b0, 1'b1, IOB + 32'h4, 32'h2, 4'hf);
    chk("frame2_tx", uart_tx, frame_bit(8'h41, 20));
    bus(1'b1, 1'b0, IOB + 32'h4, '0, '0);
    chk("status_clr", mem_data_in, 32'h1);
    chk("frame2_tx", uart_tx, frame_bit(8'h41, 21));
    reset_n = 1'b0;
    tick();
    chk("midrst_tx", uart_tx, 1'b1);
    chk("midrst_hold", hold, 1'b0);
    chk("midrst_rdata", mem_data_in, 32'h0);
    reset_n = 1'b1;
    tick();
    bus(1'b1, 1'b0, IOB + 32'h4, '0, '0);
    chk("midrst_status", mem_data_in, 32'h0);
    chk("midrst_idle", uart_tx, 1'b1);
    rb = 8'($urandom);
    send_frame(rb);
    exp_c = cyc_ref;
    bus(1'b1, 1'b0, IOB + 32'h8, '0, '0);
    chk("cycle_late", mem_data_in, exp_c);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
